// File: rtl/ifm_window_feeder_pkg.sv
// Shared types and width helpers for the IFM window feeder, line buffer and conv controller.
package ifm_window_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      WAIT   = 2'd2
   } feeder_state_e;

   // $clog2 that never returns less than one bit, so single-valued fields stay legal.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DATA_WIDTH_DEF        = 32;
   localparam int IFM_SIZE_DEF          = 14;
   localparam int IFM_DEPTH_DEF         = 3;
   localparam int KERNAL_SIZE_DEF       = 5;
   localparam int IFM_SIZE_NEXT_DEF     = IFM_SIZE_DEF - KERNAL_SIZE_DEF + 1;
   localparam int ADDRESS_SIZE_IFM_DEF  = $clog2(IFM_SIZE_DEF * IFM_SIZE_DEF);
   localparam int DEPTH_BITS_DEF        = clog2_min1(IFM_DEPTH_DEF);
   localparam int ADDRESS_SIZE_NEXT_DEF = clog2_min1(IFM_SIZE_NEXT_DEF);

endpackage

// File: rtl/ifm_window_feeder_pos_counter.sv
// Issue-position counter: col/row/channel wrap counter with a running in-channel
// address and a flag marking the last pixel of the last channel.
module ifm_pos_counter
   import ifm_window_feeder_pkg::*;
#(
   parameter int SIZE   = IFM_SIZE_DEF,
   parameter int DEPTH  = IFM_DEPTH_DEF,
   parameter int POS_W  = clog2_min1(IFM_SIZE_DEF),
   parameter int ADDR_W = ADDRESS_SIZE_IFM_DEF,
   parameter int SEL_W  = DEPTH_BITS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   output logic [POS_W-1:0]  col,
   output logic [POS_W-1:0]  row,
   output logic [SEL_W-1:0]  ch,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [POS_W-1:0]  col_q, col_d;
   logic [POS_W-1:0]  row_q, row_d;
   logic [SEL_W-1:0]  ch_q, ch_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              col_wrap, row_wrap, ch_wrap;

   assign col_wrap = (col_q == POS_W'(SIZE - 1));
   assign row_wrap = (row_q == POS_W'(SIZE - 1));
   assign ch_wrap  = (ch_q == SEL_W'(DEPTH - 1));

   // Advance one pixel per enabled cycle; the address follows col and clears at channel change.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      ch_d   = ch_q;
      addr_d = addr_q;
      if (en) begin
         if (!col_wrap) begin
            col_d  = col_q + POS_W'(1);
            addr_d = addr_q + ADDR_W'(1);
         end else begin
            col_d = '0;
            if (!row_wrap) begin
               row_d  = row_q + POS_W'(1);
               addr_d = addr_q + ADDR_W'(1);
            end else begin
               row_d  = '0;
               addr_d = '0;
               ch_d   = ch_wrap ? '0 : ch_q + SEL_W'(1);
            end
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q  <= '0;
         row_q  <= '0;
         ch_q   <= '0;
         addr_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         ch_q   <= ch_d;
         addr_q <= addr_d;
      end
   end

   assign col  = col_q;
   assign row  = row_q;
   assign ch   = ch_q;
   assign addr = addr_q;
   assign last = col_wrap && row_wrap && ch_wrap;

endmodule

// File: rtl/ifm_window_feeder.sv
// Streams all channels of one IFM from the IFM memory into the KxK line buffer and
// flags each push after which the buffer taps hold a complete window.
//
// state  | meaning
// IDLE   | waiting for start, all outputs quiet
// STREAM | issuing one read per non-stalled cycle
// WAIT   | last read issued, draining its push and window flag
module ifm_window_feeder
   import ifm_window_feeder_pkg::*;
#(
   parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
   parameter int IFM_SIZE          = IFM_SIZE_DEF,
   parameter int IFM_DEPTH         = IFM_DEPTH_DEF,
   parameter int KERNAL_SIZE       = KERNAL_SIZE_DEF,
   parameter int IFM_SIZE_NEXT     = IFM_SIZE - KERNAL_SIZE + 1,
   parameter int ADDRESS_SIZE_IFM  = $clog2(IFM_SIZE * IFM_SIZE),
   parameter int DEPTH_BITS        = clog2_min1(IFM_DEPTH),
   parameter int ADDRESS_SIZE_NEXT = clog2_min1(IFM_SIZE_NEXT)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stall,
   output logic                         ifm_rd_en,
   output logic [ADDRESS_SIZE_IFM-1:0]  ifm_addr,
   output logic [DEPTH_BITS-1:0]        ifm_sel,
   input  logic [DATA_WIDTH-1:0]        ifm_data_in,
   output logic                         fifo_enable,
   output logic [DATA_WIDTH-1:0]        fifo_data_out,
   output logic                         window_valid,
   output logic [ADDRESS_SIZE_NEXT-1:0] out_row,
   output logic [ADDRESS_SIZE_NEXT-1:0] out_col,
   output logic [DEPTH_BITS-1:0]        out_ch,
   output logic                         busy,
   output logic                         done
);

   localparam int POS_W = clog2_min1(IFM_SIZE);
   localparam int K1    = KERNAL_SIZE - 1;

   feeder_state_e state_q, state_d;

   logic                         issue;
   logic [POS_W-1:0]             pos_col, pos_row;
   logic [DEPTH_BITS-1:0]        pos_ch;
   logic [ADDRESS_SIZE_IFM-1:0]  pos_addr;
   logic                         pos_last;

   logic                         rd_valid_q, rd_valid_d;
   logic [POS_W-1:0]             d_row_q, d_row_d;
   logic [POS_W-1:0]             d_col_q, d_col_d;
   logic [DEPTH_BITS-1:0]        d_ch_q, d_ch_d;
   logic                         window_valid_q, window_valid_d;
   logic [ADDRESS_SIZE_NEXT-1:0] out_row_q, out_row_d;
   logic [ADDRESS_SIZE_NEXT-1:0] out_col_q, out_col_d;
   logic [DEPTH_BITS-1:0]        out_ch_q, out_ch_d;
   logic                         done_q, done_d;
   logic [POS_W-1:0]             row_off, col_off;

   assign issue = (state_q == STREAM) && !stall;

   ifm_pos_counter #(
      .SIZE   (IFM_SIZE),
      .DEPTH  (IFM_DEPTH),
      .POS_W  (POS_W),
      .ADDR_W (ADDRESS_SIZE_IFM),
      .SEL_W  (DEPTH_BITS)
   ) u_pos (
      .clk   (clk),
      .reset (reset),
      .en    (issue),
      .col   (pos_col),
      .row   (pos_row),
      .ch    (pos_ch),
      .addr  (pos_addr),
      .last  (pos_last)
   );

   // Next-state: leave WAIT on the cycle the final window is flagged.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = STREAM;
         STREAM:  if (issue && pos_last) state_d = WAIT;
         WAIT:    if (done_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Push pipeline and window detection one cycle behind the read.
   always_comb begin
      rd_valid_d     = issue;
      d_row_d        = pos_row;
      d_col_d        = pos_col;
      d_ch_d         = pos_ch;
      row_off        = d_row_q - POS_W'(K1);
      col_off        = d_col_q - POS_W'(K1);
      window_valid_d = rd_valid_q && (d_row_q >= POS_W'(K1)) && (d_col_q >= POS_W'(K1));
      out_row_d      = out_row_q;
      out_col_d      = out_col_q;
      out_ch_d       = out_ch_q;
      if (window_valid_d) begin
         out_row_d = row_off[ADDRESS_SIZE_NEXT-1:0];
         out_col_d = col_off[ADDRESS_SIZE_NEXT-1:0];
         out_ch_d  = d_ch_q;
      end
      done_d = window_valid_d
               && (row_off == POS_W'(IFM_SIZE_NEXT - 1))
               && (col_off == POS_W'(IFM_SIZE_NEXT - 1))
               && (d_ch_q == DEPTH_BITS'(IFM_DEPTH - 1));
   end

   // State and pipeline registers; reset aborts any stream in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         rd_valid_q     <= 1'b0;
         d_row_q        <= '0;
         d_col_q        <= '0;
         d_ch_q         <= '0;
         window_valid_q <= 1'b0;
         out_row_q      <= '0;
         out_col_q      <= '0;
         out_ch_q       <= '0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_valid_q     <= rd_valid_d;
         d_row_q        <= d_row_d;
         d_col_q        <= d_col_d;
         d_ch_q         <= d_ch_d;
         window_valid_q <= window_valid_d;
         out_row_q      <= out_row_d;
         out_col_q      <= out_col_d;
         out_ch_q       <= out_ch_d;
         done_q         <= done_d;
      end
   end

   assign ifm_rd_en     = issue;
   assign ifm_addr      = pos_addr;
   assign ifm_sel       = pos_ch;
   assign fifo_enable   = rd_valid_q;
   // Memory data is forwarded only on push cycles so the bus stays quiet otherwise.
   assign fifo_data_out = rd_valid_q ? ifm_data_in : '0;
   assign window_valid  = window_valid_q;
   assign out_row       = out_row_q;
   assign out_col       = out_col_q;
   assign out_ch        = out_ch_q;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;

endmodule

// File: tb/tb_ifm_window_feeder.sv
// Bench for ifm_window_feeder: per-cycle comparison against an arithmetic model of
// the pixel stream (pixel index -> read / push / window cycles).
module tb_ifm_window_feeder;

   localparam int N     = 14;
   localparam int D     = 3;
   localparam int K     = 5;
   localparam int NN    = N * N;
   localparam int TOTAL = NN * D;
   localparam int MAXC  = 1500;

   logic        clk = 1'b0;
   logic        reset, start, stall;
   logic [31:0] ifm_data_in;
   logic        ifm_rd_en, fifo_enable, window_valid, busy, done;
   logic [7:0]  ifm_addr;
   logic [1:0]  ifm_sel, out_ch;
   logic [31:0] fifo_data_out;
   logic [3:0]  out_row, out_col;

   int n_tests = 0;
   int n_fail  = 0;

   int mem [D][NN];
   bit stall_pat [MAXC+3];

   bit e_rd [MAXC+3], e_push [MAXC+3], e_win [MAXC+3], e_done [MAXC+3], e_busy [MAXC+3];
   int e_addr [MAXC+3], e_sel [MAXC+3], e_data [MAXC+3];
   int e_row [MAXC+3], e_col [MAXC+3], e_ch [MAXC+3];
   int last_c;

   bit obs_win [MAXC+3], obs_push [MAXC+3];
   int n_push, n_win, first_win, done_c;

   ifm_window_feeder dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stall         (stall),
      .ifm_rd_en     (ifm_rd_en),
      .ifm_addr      (ifm_addr),
      .ifm_sel       (ifm_sel),
      .ifm_data_in   (ifm_data_in),
      .fifo_enable   (fifo_enable),
      .fifo_data_out (fifo_data_out),
      .window_valid  (window_valid),
      .out_row       (out_row),
      .out_col       (out_col),
      .out_ch        (out_ch),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Synchronous IFM memory: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (ifm_rd_en) ifm_data_in <= 32'(mem[ifm_sel][ifm_addr]);
   end

   function automatic void fill_mem_default();
      for (int ch = 0; ch < D; ch++)
         for (int a = 0; a < NN; a++) mem[ch][a] = ch * 256 + a;
   endfunction

   function automatic void clear_stall();
      for (int c = 0; c < MAXC + 3; c++) stall_pat[c] = 1'b0;
   endfunction

   // Pixel p is read on its issue cycle, pushed one cycle later, flagged two cycles later.
   function automatic void build_model();
      int p;
      for (int c = 0; c < MAXC + 3; c++) begin
         e_rd[c] = 0; e_push[c] = 0; e_win[c] = 0; e_done[c] = 0; e_busy[c] = 0;
         e_addr[c] = 0; e_sel[c] = 0; e_data[c] = 0; e_row[c] = 0; e_col[c] = 0; e_ch[c] = 0;
      end
      p = 0;
      last_c = 0;
      for (int c = 1; c <= MAXC; c++) begin
         if (p < TOTAL && !stall_pat[c]) begin
            int ch, a, r, cl;
            ch = p / NN;
            a  = p % NN;
            r  = a / N;
            cl = a % N;
            e_rd[c] = 1; e_addr[c] = a; e_sel[c] = ch;
            e_push[c+1] = 1; e_data[c+1] = mem[ch][a];
            if (r >= K - 1 && cl >= K - 1) begin
               e_win[c+2] = 1; e_row[c+2] = r - (K - 1); e_col[c+2] = cl - (K - 1); e_ch[c+2] = ch;
            end
            if (p == TOTAL - 1) begin
               e_done[c+2] = 1;
               last_c = c + 2;
            end
            p++;
         end
      end
      for (int c = 1; c <= last_c; c++) e_busy[c] = 1;
   endfunction

   // Pulses (or holds) start, then checks cycles 1..stop_c against the model.
   task automatic run_stream(input bit hold_start, input int stop_c);
      n_push = 0; n_win = 0; first_win = 0; done_c = 0;
      for (int c = 0; c < MAXC + 3; c++) begin obs_win[c] = 0; obs_push[c] = 0; end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = hold_start;
      for (int c = 1; c <= stop_c; c++) begin
         stall = stall_pat[c];
         @(negedge clk);
         obs_win[c]  = window_valid;
         obs_push[c] = fifo_enable;
         if (fifo_enable) n_push++;
         if (window_valid) begin
            n_win++;
            if (first_win == 0) first_win = c;
         end
         if (done) done_c = c;
         n_tests++;
         if (ifm_rd_en !== e_rd[c]) begin
            n_fail++; $display("FAIL rd_en c%0d got %b want %b", c, ifm_rd_en, e_rd[c]);
         end
         if (e_rd[c]) begin
            n_tests++;
            if (ifm_addr !== 8'(e_addr[c]) || ifm_sel !== 2'(e_sel[c])) begin
               n_fail++; $display("FAIL rd_pos c%0d got sel %0d addr %0d want sel %0d addr %0d",
                                  c, ifm_sel, ifm_addr, e_sel[c], e_addr[c]);
            end
         end
         n_tests++;
         if (fifo_enable !== e_push[c] || fifo_data_out !== 32'(e_data[c])) begin
            n_fail++; $display("FAIL push c%0d got %b/%0d want %b/%0d",
                               c, fifo_enable, fifo_data_out, e_push[c], e_data[c]);
         end
         n_tests++;
         if (window_valid !== e_win[c]) begin
            n_fail++; $display("FAIL window_valid c%0d got %b want %b", c, window_valid, e_win[c]);
         end
         if (e_win[c]) begin
            n_tests++;
            if (out_row !== 4'(e_row[c]) || out_col !== 4'(e_col[c]) || out_ch !== 2'(e_ch[c])) begin
               n_fail++; $display("FAIL coords c%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                                  c, out_row, out_col, out_ch, e_row[c], e_col[c], e_ch[c]);
            end
         end
         n_tests++;
         if (done !== e_done[c] || busy !== e_busy[c]) begin
            n_fail++; $display("FAIL done_busy c%0d got %b/%b want %b/%b",
                               c, done, busy, e_done[c], e_busy[c]);
         end
         @(posedge clk); #1;
      end
      stall = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; stall = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({ifm_rd_en, fifo_enable, window_valid, busy, done} !== 5'b0 ||
          ifm_addr !== 8'd0 || ifm_sel !== 2'd0 || fifo_data_out !== 32'd0 ||
          out_row !== 4'd0 || out_col !== 4'd0 || out_ch !== 2'd0) begin
         n_fail++; $display("FAIL reset_state got rd%b push%b win%b busy%b done%b addr%0d want all zero",
                            ifm_rd_en, fifo_enable, window_valid, busy, done, ifm_addr);
      end
   endtask

   task automatic test_full_run();
      fill_mem_default(); clear_stall(); build_model();
      run_stream(1'b0, last_c + 2);
      n_tests++;
      if (first_win !== 63) begin n_fail++; $display("FAIL first_window got %0d want 63", first_win); end
      n_tests++;
      if (obs_push[62] !== 1'b1) begin n_fail++; $display("FAIL push62 got %b want 1", obs_push[62]); end
      n_tests++;
      if (n_push !== 588 || n_win !== 300) begin
         n_fail++; $display("FAIL counts got %0d pushes %0d windows want 588 300", n_push, n_win);
      end
      n_tests++;
      if (done_c !== 590) begin n_fail++; $display("FAIL done_cycle got %0d want 590", done_c); end
      n_tests++;
      if (obs_win[73] !== 1'b0) begin n_fail++; $display("FAIL row_edge c73 got %b want 0", obs_win[73]); end
   endtask

   task automatic test_stall();
      fill_mem_default(); clear_stall();
      for (int c = 30; c <= 39; c++) stall_pat[c] = 1'b1;
      build_model();
      run_stream(1'b0, last_c + 2);
      n_tests++;
      if (obs_push[30] !== 1'b1) begin n_fail++; $display("FAIL stall_inflight got %b want 1", obs_push[30]); end
      n_tests++;
      if (first_win !== 73 || done_c !== 600) begin
         n_fail++; $display("FAIL stall_shift got first %0d done %0d want 73 600", first_win, done_c);
      end
   endtask

   task automatic test_reset_mid();
      fill_mem_default(); clear_stall(); build_model();
      run_stream(1'b0, 99);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_tests++;
         if ({ifm_rd_en, fifo_enable, window_valid, busy, done} !== 5'b0 ||
             ifm_addr !== 8'd0 || ifm_sel !== 2'd0 || fifo_data_out !== 32'd0 ||
             out_row !== 4'd0 || out_col !== 4'd0 || out_ch !== 2'd0) begin
            n_fail++; $display("FAIL mid_reset c%0d got rd%b push%b win%b busy%b done%b addr%0d want all zero",
                               101 + i, ifm_rd_en, fifo_enable, window_valid, busy, done, ifm_addr);
         end
         @(posedge clk); #1;
      end
      run_stream(1'b0, last_c + 2);
      n_tests++;
      if (first_win !== 63) begin n_fail++; $display("FAIL replay_first got %0d want 63", first_win); end
   endtask

   task automatic test_hold_start();
      fill_mem_default(); clear_stall(); build_model();
      run_stream(1'b1, last_c + 1);
      @(negedge clk);
      n_tests++;
      if (ifm_rd_en !== 1'b1 || ifm_addr !== 8'd0 || ifm_sel !== 2'd0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL restart got rd%b addr%0d sel%0d busy%b want rd1 addr0 sel0 busy1",
                            ifm_rd_en, ifm_addr, ifm_sel, busy);
      end
      start = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_random();
      for (int ch = 0; ch < D; ch++)
         for (int a = 0; a < NN; a++) mem[ch][a] = int'($urandom);
      clear_stall();
      for (int c = 1; c <= 900; c++) stall_pat[c] = ($urandom_range(0, 3) == 0);
      build_model();
      run_stream(1'b0, last_c + 2);
      n_tests++;
      if (n_push !== 588 || n_win !== 300) begin
         n_fail++; $display("FAIL rand_counts got %0d pushes %0d windows want 588 300", n_push, n_win);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stall = 1'b0;
      fill_mem_default();
      test_reset();
      test_full_run();
      test_stall();
      test_reset_mid();
      test_hold_start();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifm_window_feeder.md
Name: ifm_window_feeder

Overview:
- Streams one IFM at a time, all IFM_DEPTH channels, from the synchronous IFM memory into the 25-tap convolution line buffer.
- The line buffer is a shift FIFO of length (K-1)*IFM_SIZE+K. Each push shifts it by one.
- This block generates read addresses, drives the line buffer's push enable and data, and flags each push after which the 25 taps form a valid KxK window. It also reports that window's output coordinates.
- Sits between the IFM memory and the line buffer/MAC array of each conv layer.

Parameters:
- DATA_WIDTH, 32, pixel width.
- IFM_SIZE, 14, IFM rows = cols.
- IFM_DEPTH, 3, number of channels streamed per start.
- KERNAL_SIZE, 5, kernel size K.
- IFM_SIZE_NEXT, IFM_SIZE-KERNAL_SIZE+1, output map size.
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), in-channel address width.
- DEPTH_BITS, $clog2(IFM_DEPTH) (min 1), channel select width.
- ADDRESS_SIZE_NEXT, $clog2(IFM_SIZE_NEXT) (min 1), output coordinate width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin streaming; sampled in IDLE only.
- stall, input, 1, downstream not ready; blocks issue of new reads.
- ifm_rd_en, output, 1, memory read strobe.
- ifm_addr, output, ADDRESS_SIZE_IFM, pixel address within channel (row*IFM_SIZE+col).
- ifm_sel, output, DEPTH_BITS, channel being read.
- ifm_data_in, input, DATA_WIDTH, memory read data, valid 1 cycle after ifm_rd_en.
- fifo_enable, output, 1, line buffer push.
- fifo_data_out, output, DATA_WIDTH, pixel to line buffer (ifm_data_in passed through, unregistered).
- window_valid, output, 1, line buffer taps hold a valid window this cycle.
- out_row, output, ADDRESS_SIZE_NEXT, window top-left row.
- out_col, output, ADDRESS_SIZE_NEXT, window top-left col.
- out_ch, output, DEPTH_BITS, channel of the current window.
- busy, output, 1, high outside IDLE.
- done, output, 1, one-cycle pulse on the final window.

Behaviour:
- Reset (sync, active-high): state IDLE; all counters 0; every output 0. Reset mid-stream aborts immediately; no further push, valid or done.
- FSM IDLE -> STREAM on start=1. STREAM -> WAIT after the read of the last pixel of the last channel is issued. WAIT -> IDLE once that pixel's window_valid/done cycle completes. start while busy is ignored.
- Issue, in STREAM with stall=0: ifm_rd_en=1 with the current (ifm_sel, ifm_addr), then the position advances col++. At col wrap: row++. At row wrap: channel++ and address back to 0.
  - Channels stream back to back with no bubble.
  - No line-buffer flush is needed between channels.
- stall=1: ifm_rd_en=0 and address/position hold. A read already in flight still completes its push next cycle.
- Push: a 1-cycle delayed rd_valid plus the delayed row/col/ch. fifo_enable=rd_valid; fifo_data_out=ifm_data_in.
- Window flag: registered, asserted the cycle after the push of pixel (r,c) iff r>=K-1 and c>=K-1.
  - out_row=r-(K-1), out_col=c-(K-1), out_ch=ch, all registered with window_valid; they hold their last value otherwise.
  - By the r>=K-1, c>=K-1 condition, every tap belongs to the current channel.
- Latency, counting cycle 1 as the first cycle after start is sampled: pixel p read in cycle p+1, pushed in cycle p+2, window flagged in cycle p+3 (no stall).
- done: asserted together with window_valid for the pixel (N-1,N-1) of channel IFM_DEPTH-1. FSM is in IDLE the next cycle; start is accepted from that cycle.
- Counter widths exactly as parameters; no overflow past the wrap values.

Decomposition:
- Shared package: state enum (IDLE, STREAM, WAIT) and $clog2-derived width constants, shared with the line buffer and the conv controller.
- One sub-module: ifm_pos_counter, the enabled col/row/channel wrap counter with last-pixel flag. It is used for the issue position only; the delayed copy is plain registers.

Test Plan:
- Defaults, memory holds value = ch*256+addr, start pulse, stall=0 -> first window_valid in cycle 63 with (row 0, col 0, ch 0); fifo_data_out in cycle 62 = 60.
- Full run, no stall -> exactly 588 fifo_enable and 300 window_valid pulses; done only in cycle 590 with (9,9,2); busy low from cycle 591.
- Row edge -> the pushes of pixels with col 0..3 in rows >=4 never flag window_valid; e.g. pixel 70 (row 5, col 0) -> no flag in cycle 73.
- stall high for cycles 30..39 -> no rd_en in those cycles; the read in flight from cycle 29 still pushes in cycle 30; window sequence is identical, shifted by 10 cycles.
- reset asserted in cycle 100 -> from cycle 101 all outputs 0 and state IDLE; a new start replays from address 0 with the first window 63 cycles later.
- start held high throughout the run -> no restart mid-stream; a new run begins the cycle after done.
